gtp_loopback_top: RTL and testbench
===================================

# gtp_loopback_top

Single-clock serial link block that runs one transmit and one receive lane over a differential pin pair.
- Transmit side: buffers 32-bit words generated from an internal counter into a FIFO, frames them, and serializes them one bit per clock on `gtp_tx_p/n`. When it has no data to send, it transmits idle frames.
- Receive side: deserializes `gtp_rx_p` and finds frame alignment using the idle pattern. It raises `rxinit_done` once the link is locked, then delivers the received payloads.
- Intended for board-level loopback, with `gtp_tx_*` wired to `gtp_rx_*`.

## Interface
- Parameters:
- `FIFO_DEPTH`, default 16: TX FIFO depth in words (power of two).
- `LOCK_FRAMES`, default 8: consecutive good headers needed to lock.
- `UNLOCK_FRAMES`, default 4: consecutive bad headers that drop lock.
- `IDLE_WORD`, default 32'hBC5050BC: idle payload.
- Ports (one clock; reset is synchronous and active-high):
- `write_clk` in 1: the only clock; all logic runs on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `we` in 1: write-enable for the counter word into the TX FIFO.
- `link_ready` in 1: allows data frames to be sent (otherwise idle only).
- `trans_en` in 1: allows words to be popped from the TX FIFO.
- `gtp_tx_p` out 1: serial TX, true polarity.
- `gtp_tx_n` out 1: serial TX, always the inverse of `gtp_tx_p`.
- `gtp_rx_p` in 1: serial RX, true polarity (the only RX pin that is sampled).
- `gtp_rx_n` in 1: serial RX complement; ignored.
- `rxinit_done` out 1: RX is aligned and locked.
- `rx_data` out 32: payload of the last received data frame.
- `rx_valid` out 1: one-cycle strobe for `rx_data`.
- `rx_err` out 1: one-cycle strobe when a control frame payload is not `IDLE_WORD` while locked.

## Operation
- Reset values: `gtp_tx_p`=0, `gtp_tx_n`=1, `rxinit_done`=0, `rx_valid`=0, `rx_err`=0, `rx_data`=0. Reset also clears the FIFO, the word counter (`value`), the TX/RX bit counters and the RX state machine (to HUNT).
- Word source:
  - When `we`=1 and the FIFO is not full, `value` is written and `value` increments (32-bit wrap).
  - When `we`=1 and the FIFO is full, the write is dropped and `value` does not change.
- Frame format: 34 bits sent MSB first, a 2-bit header followed by the 32-bit payload.
  - Data frame: header 2'b01, payload is the data word.
  - Idle frame: header 2'b10, payload is `IDLE_WORD`.
- TX frame selection at each frame boundary:
  - If `link_ready`=1, `trans_en`=1 and the FIFO is not empty: pop one word and send it as a data frame.
  - Otherwise: send an idle frame.
  - Idle frames are sent continuously from reset onward so the receiver can lock.
- A pop and a write in the same cycle are both honoured. A write to a full FIFO that coincides with a pop is accepted.
- RX state machine, shifting in `gtp_rx_p` every cycle:
  - HUNT: checks the 34-bit shift register each cycle. When it equals the complete idle frame, the frame phase is fixed at that bit and the state goes to VERIFY with good=1.
  - VERIFY: checks the header once per frame. A header in {01,10} increments good; reaching `LOCK_FRAMES` moves to LOCKED and sets `rxinit_done`=1. Any other header returns to HUNT.
  - LOCKED, on each frame:
    - Header 01: `rx_data` is set to the payload and `rx_valid` pulses.
    - Header 10 with a payload other than `IDLE_WORD`: `rx_err` pulses.
    - Invalid header: the bad count increments; reaching `UNLOCK_FRAMES` returns to HUNT and clears `rxinit_done`.
    - Any valid header resets the bad count.
- `rx_data` holds its value between strobes.

## Timing
- TX:
  - Frame bit i is driven on `gtp_tx_p` during cycle T+i (i=0..33). Frames follow back to back with no gap.
  - The first frame after reset starts in the cycle after `rst` deasserts.
  - The FIFO pop and the frame-type decision are registered in the cycle before T.
- RX:
  - For a frame starting in cycle T on `gtp_rx_p`, `rx_valid`/`rx_err` are high exactly during cycle T+35.
  - `rxinit_done` rises in that same T+35 cycle for the `LOCK_FRAMES`-th good frame.
- In loopback from reset, `rxinit_done`=1 no later than cycle 320.
- `we` is accepted in the same cycle it is asserted (registered write).
- Reset applied mid-frame aborts the frame: the TX line goes to 0 and RX returns to HUNT on the next edge.

## Test plan
- Reset, loopback, all inputs 0 → only idle frames are sent; `rxinit_done` rises ≤ cycle 320; `rx_valid` and `rx_err` never pulse.
- After lock, `link_ready`=1 with the FIFO empty → only idle frames, no `rx_valid`, `rxinit_done` stays 1.
- Pulse `we` for 5 cycles, then set `link_ready`=1, `trans_en`=1 → `rx_valid` pulses 5 times with `rx_data` = 0,1,2,3,4 in order, 34 cycles apart.
- Hold `we` for 20 cycles with `trans_en`=0 → 16 words are stored and `value` ends at 16. Then enable `trans_en` → exactly 0..15 are received, then idle.
- With `we`=1 and `trans_en`=1 continuously → the received words are a gap-free increasing sequence; drop `we` for 11 cycles, then resume → the sequence stays contiguous.
- After lock, force `gtp_rx_p`=0 for 4 frames → `rxinit_done` falls; release it → relock within 10 frames.

Source files
------------

// File: rtl/gtp_loopback_top.sv
// rtl/gtp_loopback_top.sv - serial loopback link: counter-fed TX FIFO, 34-bit framed serializer, idle-aligned RX
module gtp_loopback_top #(
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned LOCK_FRAMES   = 8,
  parameter int unsigned UNLOCK_FRAMES = 4,
  parameter logic [31:0] IDLE_WORD     = 32'hBC5050BC
) (
  input  logic        write_clk,
  input  logic        rst,
  input  logic        we,
  input  logic        link_ready,
  input  logic        trans_en,
  output logic        gtp_tx_p,
  output logic        gtp_tx_n,
  input  logic        gtp_rx_p,
  input  logic        gtp_rx_n,
  output logic        rxinit_done,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  output logic        rx_err
);
  localparam int          AW         = $clog2(FIFO_DEPTH);
  localparam logic [33:0] IDLE_FRAME = {2'b10, IDLE_WORD};
  localparam logic [15:0] LOCK_N     = 16'(LOCK_FRAMES);
  localparam logic [15:0] UNLOCK_N   = 16'(UNLOCK_FRAMES);

  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [31:0] value;
  logic        fifo_empty, fifo_full, do_pop, do_push;
  logic [33:0] tx_sr;
  logic [5:0]  tx_cnt;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // The pop happens on the edge that loads the next frame, so a full FIFO can still accept a write then.
  assign do_pop     = (tx_cnt == 6'd33) && link_ready && trans_en && !fifo_empty;
  assign do_push    = we && (!fifo_full || do_pop);

  always_ff @(posedge write_clk) begin
    if (!rst && do_push) mem[wr_ptr[AW-1:0]] <= value;
  end

  always_ff @(posedge write_clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      value  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
        value  <= value + 32'd1;
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge write_clk) begin
    if (rst) begin
      tx_sr    <= IDLE_FRAME;
      tx_cnt   <= '0;
      gtp_tx_p <= 1'b0;
      gtp_tx_n <= 1'b1;
    end else begin
      gtp_tx_p <= tx_sr[33];
      gtp_tx_n <= ~tx_sr[33];
      if (tx_cnt == 6'd33) begin
        tx_cnt <= '0;
        tx_sr  <= do_pop ? {2'b01, mem[rd_ptr[AW-1:0]]} : IDLE_FRAME;
      end else begin
        tx_cnt <= tx_cnt + 6'd1;
        tx_sr  <= {tx_sr[32:0], 1'b0};
      end
    end
  end

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} rx_state_t;

  rx_state_t   rx_state;
  logic [33:0] rx_sr;
  logic [5:0]  rx_cnt;
  logic [15:0] good_cnt, bad_cnt;
  logic [1:0]  rx_hdr;
  logic        hdr_ok;
  logic        rx_n_unused;

  assign rx_hdr      = rx_sr[33:32];
  assign hdr_ok      = (rx_hdr == 2'b01) || (rx_hdr == 2'b10);
  assign rx_n_unused = gtp_rx_n;

  // rx_cnt == 33 marks the cycle in which rx_sr holds one complete frame in phase.
  always_ff @(posedge write_clk) begin
    if (rst) begin
      rx_state    <= HUNT;
      rx_sr       <= '0;
      rx_cnt      <= '0;
      good_cnt    <= '0;
      bad_cnt     <= '0;
      rxinit_done <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_err      <= 1'b0;
    end else begin
      rx_sr    <= {rx_sr[32:0], gtp_rx_p};
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      rx_cnt   <= (rx_cnt == 6'd33) ? 6'd0 : rx_cnt + 6'd1;
      case (rx_state)
        HUNT: begin
          if (rx_sr == IDLE_FRAME) begin
            rx_state <= VERIFY;
            good_cnt <= 16'd1;
            rx_cnt   <= '0;
          end
        end
        VERIFY: begin
          if (rx_cnt == 6'd33) begin
            if (!hdr_ok) begin
              rx_state <= HUNT;
            end else if (good_cnt + 16'd1 >= LOCK_N) begin
              rx_state    <= LOCKED;
              rxinit_done <= 1'b1;
              bad_cnt     <= '0;
            end else begin
              good_cnt <= good_cnt + 16'd1;
            end
          end
        end
        LOCKED: begin
          if (rx_cnt == 6'd33) begin
            if (hdr_ok) begin
              bad_cnt <= '0;
              if (rx_hdr == 2'b01) begin
                rx_data  <= rx_sr[31:0];
                rx_valid <= 1'b1;
              end else if (rx_sr[31:0] != IDLE_WORD) begin
                rx_err <= 1'b1;
              end
            end else if (bad_cnt + 16'd1 >= UNLOCK_N) begin
              rx_state    <= HUNT;
              rxinit_done <= 1'b0;
            end else begin
              bad_cnt <= bad_cnt + 16'd1;
            end
          end
        end
        default: rx_state <= HUNT;
      endcase
    end
  end
endmodule

// File: tb/tb_gtp_loopback_top.sv
// tb/tb_gtp_loopback_top.sv - randomized loopback bench checked against a frame-level model
`timescale 1ns/1ps
module tb_gtp_loopback_top;
  logic        write_clk = 1'b0;
  logic        rst = 1'b1, we = 1'b0, link_ready = 1'b0, trans_en = 1'b0, force_zero = 1'b0;
  logic        gtp_tx_p, gtp_tx_n, gtp_rx_p, gtp_rx_n, rxinit_done, rx_valid, rx_err;
  logic [31:0] rx_data;

  assign gtp_rx_p = force_zero ? 1'b0 : gtp_tx_p;
  assign gtp_rx_n = ~gtp_rx_p;

  gtp_loopback_top dut (
    .write_clk(write_clk), .rst(rst), .we(we), .link_ready(link_ready), .trans_en(trans_en),
    .gtp_tx_p(gtp_tx_p), .gtp_tx_n(gtp_tx_n), .gtp_rx_p(gtp_rx_p), .gtp_rx_n(gtp_rx_n),
    .rxinit_done(rxinit_done), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err)
  );

  always #5 write_clk = ~write_clk;

  int          n_checks = 0, n_pass = 0;
  int          cyc = 0, t0 = 0;
  int          n_err = 0, n_inv = 0;
  logic        hist [8192];
  logic [33:0] mon_fr;
  logic [31:0] rxq [$];
  int          rx_time [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(posedge write_clk) cyc++;

  // Line history lets every received word be matched to the frame seen on gtp_rx_p 35 cycles earlier.
  always @(negedge write_clk) begin
    hist[cyc % 8192] = gtp_rx_p;
    if (gtp_tx_n !== ~gtp_tx_p) n_inv++;
    if (rx_err === 1'b1) n_err++;
    if (rx_valid === 1'b1) begin
      for (int i = 0; i < 34; i++) mon_fr[33-i] = hist[(cyc - 35 + i) % 8192];
      chk("frame_on_line", {30'd0, mon_fr}, {30'd0, 2'b01, rx_data});
      rxq.push_back(rx_data);
      rx_time.push_back(cyc);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge write_clk);
    #1;
  endtask

  task automatic wait_words(input string tag, input int n, input int bound);
    int lim;
    lim = cyc + bound;
    while (rxq.size() < n && cyc < lim) @(negedge write_clk);
    chk(tag, rxq.size(), n);
  endtask

  initial begin
    logic [31:0] model_val;
    logic [31:0] expq [$];
    int          base, lim;

    model_val = 32'd0;
    cycles(3);
    @(negedge write_clk);
    chk("rst_tx_p", gtp_tx_p, 1'b0);
    chk("rst_tx_n", gtp_tx_n, 1'b1);
    chk("rst_rxinit_done", rxinit_done, 1'b0);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_err", rx_err, 1'b0);
    chk("rst_rx_data", rx_data, 32'd0);
    @(posedge write_clk);
    #1 rst = 1'b0;
    t0 = cyc + 1;

    // Frame 0 is found in HUNT, frames 1..7 complete the eight good headers.
    lim = t0 + 400;
    while (rxinit_done !== 1'b1 && cyc < lim) @(negedge write_clk);
    chk("lock_cycle", cyc, t0 + 34 * 7 + 35);
    chk("lock_by_320", (cyc - t0 + 1) <= 320, 1'b1);

    link_ready = 1'b1;
    cycles($urandom_range(150, 250));
    chk("idle_no_valid", rxq.size(), 0);
    chk("idle_still_locked", rxinit_done, 1'b1);

    we = 1'b1;
    cycles(5);
    we = 1'b0;
    for (int i = 0; i < 5; i++) expq.push_back(model_val++);
    trans_en = 1'b1;
    wait_words("five_count", 5, 400);
    for (int i = 0; i < 5 && i < rxq.size(); i++) chk("five_word", rxq[i], expq[i]);
    for (int i = 1; i < 5 && i < rx_time.size(); i++) chk("five_spacing", rx_time[i] - rx_time[i-1], 34);
    trans_en = 1'b0;
    rxq.delete(); rx_time.delete(); expq.delete();

    for (int i = 0; i < 12; i++) begin
      we = 1'($urandom_range(0, 1));
      if (we) expq.push_back(model_val++);
      cycles(1);
    end
    we = 1'b0;
    trans_en = 1'b1;
    wait_words("rand_count", expq.size(), expq.size() * 34 + 100);
    for (int i = 0; i < expq.size() && i < rxq.size(); i++) chk("rand_word", rxq[i], expq[i]);
    cycles(100);
    chk("rand_then_idle", rxq.size(), expq.size());
    trans_en = 1'b0;
    rxq.delete(); rx_time.delete(); expq.delete();

    we = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i < 16) expq.push_back(model_val++);
      cycles(1);
    end
    we = 1'b0;
    trans_en = 1'b1;
    wait_words("full_count", 16, 16 * 34 + 200);
    for (int i = 0; i < 16 && i < rxq.size(); i++) chk("full_word", rxq[i], expq[i]);
    cycles(150);
    chk("full_then_idle", rxq.size(), 16);
    we = 1'b1;
    cycles(1);
    we = 1'b0;
    wait_words("after_full_count", 17, 150);
    if (rxq.size() > 16) chk("value_after_full", rxq[16], model_val);
    model_val++;
    rxq.delete(); rx_time.delete(); expq.delete();

    base = int'(model_val);
    we = 1'b1;
    cycles($urandom_range(300, 450));
    we = 1'b0;
    cycles(11);
    we = 1'b1;
    cycles($urandom_range(200, 300));
    we = 1'b0;
    cycles(17 * 34 + 100);
    chk("stream_nonempty", rxq.size() > 10, 1'b1);
    for (int i = 0; i < rxq.size(); i++) chk("stream_contig", rxq[i], 32'(base + i));
    model_val = 32'(base + rxq.size());
    chk("rx_data_holds", rx_data, model_val - 32'd1);
    we = 1'b1;
    cycles(1);
    we = 1'b0;
    base = rxq.size();
    wait_words("stream_resume_count", base + 1, 150);
    if (rxq.size() > base) chk("stream_resume_word", rxq[base], model_val);
    model_val++;
    trans_en = 1'b0;
    rxq.delete(); rx_time.delete();

    do begin
      @(posedge write_clk);
      #1;
    end while ((cyc - t0) % 34 != 0);
    force_zero = 1'b1;
    cycles(4 * 34);
    force_zero = 1'b0;
    cycles(4);
    chk("unlock", rxinit_done, 1'b0);
    lim = cyc + 10 * 34;
    while (rxinit_done !== 1'b1 && cyc < lim) @(negedge write_clk);
    chk("relock", rxinit_done, 1'b1);
    chk("force_no_valid", rxq.size(), 0);

    chk("tx_n_inverse", n_inv, 0);
    chk("no_rx_err", n_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
